inst_mem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the pipelined core; it is the successor to the fixed 256-word combinational instruction ROM. Sits between the fetch stage and the IF/ID register. Adds:
- registered fetch with valid/ready backpressure;
- branch flush;
- a run-time program-load port;
- an optional post-reset clear sweep;
- fault reporting for bad fetch addresses.

---
 rtl/inst_mem_pkg.sv | 32 +++
 rtl/inst_mem_array.sv | 23 ++
 rtl/inst_mem_sync.sv | 129 ++++++++++++
 tb/tb_inst_mem_sync.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// The fault check is used by both the fetch and program-load paths.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    PROG  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Byte address must be word aligned and must not reach past the last word.
  function automatic logic addr_fault(input logic [63:0] addr, input int addr_w, input int idx_w);
    logic f;
    f = (addr[1:0] != 2'b00);
    for (int i = 2; i < 64; i++) begin
      if ((i >= idx_w + 2) && (i < addr_w) && addr[i]) f = 1'b1;
    end
    return f;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// 1-read 1-write synchronous RAM; a same-edge read of a written index returns the old word.
module inst_mem_array #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory with fetch handshake, flush,
// program-load mode and an optional NOP clear sweep after reset.
//
// state | meaning
// CLEAR | sweeping NOP_WORD into every word, fetch and program blocked
// RUN   | normal fetch, 1-cycle latency, valid/ready backpressure
// PROG  | program-load writes from prog_*, fetch blocked
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    DEPTH          = 256,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = DATA_WIDTH'(NOP_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_inst,
  output logic                  resp_fault,
  input  logic                  flush,
  input  logic                  prog_en,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  busy
);

  localparam int             IDX_W    = clog2(DEPTH);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W + 1)'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [IDX_W:0]        clr_cnt_q, clr_cnt_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_fault_q, resp_fault_d;
  logic                  resp_nop_q, resp_nop_d;

  logic                  req_fault, prog_fault, accept;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  assign req_fault  = addr_fault(64'(req_addr), ADDR_WIDTH, IDX_W);
  assign prog_fault = addr_fault(64'(prog_addr), ADDR_WIDTH, IDX_W);

  assign req_ready  = (state_q == RUN) && (!resp_valid_q || resp_ready) && !flush;
  assign accept     = req_valid && req_ready;
  assign busy       = (state_q != RUN);
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  // The RAM output only moves on an accept, so masking it gives a held response.
  assign resp_inst  = resp_nop_q ? NOP_WORD : mem_rdata;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = NOP_WORD;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q[IDX_W-1:0];
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CNT_LAST) state_d = RUN;
      end
      RUN: begin
        if (prog_en) state_d = PROG;
      end
      PROG: begin
        mem_we    = prog_we && !prog_fault;
        mem_waddr = prog_addr[IDX_W+1:2];
        mem_wdata = prog_data;
        if (!prog_en) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_fault_d = resp_fault_q;
    resp_nop_d   = resp_nop_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_fault_d = req_fault;
      resp_nop_d   = req_fault;
    end else if (flush || resp_ready) begin
      resp_valid_d = 1'b0;
    end
    if (state_d != RUN) resp_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_nop_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_nop_q   <= resp_nop_d;
    end
  end

  inst_mem_array #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (accept),
    .raddr_i(req_addr[IDX_W+1:2]),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed bench for inst_mem_sync: clear sweep, program load, fetch, stall, flush, faults, reset.
module tb_inst_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_inst;
  logic        resp_fault;
  logic        flush, prog_en, prog_we;
  logic [31:0] prog_addr, prog_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  inst_mem_sync #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .CLEAR_ON_RESET(1'b1), .NOP_WORD(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_fault(resp_fault),
    .flush(flush), .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      if (req_ready !== 1'b0) chk("ready_in_clear", 32'(req_ready), 32'h0);
      tick();
      cnt++;
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  task automatic pwrite(input logic [31:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    flush = 1'b0; prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    tick(); tick();
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_inst", resp_inst, 32'h0);
    chk("rst_fault", 32'(resp_fault), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);

    rst_n = 1'b1;
    count_busy(n);
    chk("sweep_len", 32'(n), 32'd256);

    req_valid = 1'b1; req_addr = 32'h3FC; #1;
    chk("run_ready", 32'(req_ready), 32'h1);
    fetch(32'h3FC);
    chk("f3fc_valid", 32'(resp_valid), 32'h1);
    chk("f3fc_inst", resp_inst, 32'h0);
    chk("f3fc_fault", 32'(resp_fault), 32'h0);

    prog_en = 1'b1;
    tick(); #1;
    chk("prog_busy", 32'(busy), 32'h1);
    chk("prog_ready", 32'(req_ready), 32'h0);
    chk("prog_valid", 32'(resp_valid), 32'h0);
    pwrite(32'h000, 32'h8001_0000);
    pwrite(32'h004, 32'h0400_0800);
    pwrite(32'h400, 32'hDEAD_BEEF);
    prog_en = 1'b0;
    tick(); #1;
    chk("run_busy", 32'(busy), 32'h0);

    // back-to-back fetch
    req_valid = 1'b1; req_addr = 32'h000;
    tick();
    chk("b2b0_valid", 32'(resp_valid), 32'h1);
    chk("b2b0_inst", resp_inst, 32'h8001_0000);
    req_addr = 32'h004; #1;
    chk("b2b1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("b2b1_valid", 32'(resp_valid), 32'h1);
    chk("b2b1_inst", resp_inst, 32'h0400_0800);
    req_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(resp_valid), 32'h0);
    chk("drain_hold", resp_inst, 32'h0400_0800);

    // stall
    fetch(32'h000);
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h004; #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_valid", 32'(resp_valid), 32'h1);
      chk("stall_inst", resp_inst, 32'h8001_0000);
      tick();
    end
    resp_ready = 1'b1; #1;
    chk("unstall_ready", 32'(req_ready), 32'h1);
    tick();
    chk("unstall_inst", resp_inst, 32'h0400_0800);
    req_valid = 1'b0;
    tick();

    // flush while stalled
    fetch(32'h000);
    chk("preflush_inst", resp_inst, 32'h8001_0000);
    resp_ready = 1'b0; flush = 1'b1; req_valid = 1'b1; req_addr = 32'h004; #1;
    chk("flush_ready", 32'(req_ready), 32'h0);
    tick();
    flush = 1'b0; resp_ready = 1'b1; #1;
    chk("flush_valid", 32'(resp_valid), 32'h0);
    chk("postflush_ready", 32'(req_ready), 32'h1);
    tick();
    chk("postflush_inst", resp_inst, 32'h0400_0800);
    chk("postflush_valid", 32'(resp_valid), 32'h1);
    req_valid = 1'b0;
    tick();

    // faults
    fetch(32'h002);
    chk("mis_fault", 32'(resp_fault), 32'h1);
    chk("mis_inst", resp_inst, 32'h0);
    fetch(32'h400);
    chk("oor_fault", 32'(resp_fault), 32'h1);
    chk("oor_inst", resp_inst, 32'h0);
    fetch(32'h000);
    chk("w0_fault", 32'(resp_fault), 32'h0);
    chk("w0_inst", resp_inst, 32'h8001_0000);
    fetch(32'h3FC);
    chk("w255_inst", resp_inst, 32'h0);

    // reset with a live response, then reset mid-sweep
    resp_ready = 1'b0;
    fetch(32'h004);
    chk("prerst_valid", 32'(resp_valid), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", 32'(resp_valid), 32'h0);
    chk("rst2_inst", resp_inst, 32'h0);
    resp_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("midsweep_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rst3_valid", 32'(resp_valid), 32'h0);
    rst_n = 1'b1;
    count_busy(n);
    chk("resweep_len", 32'(n), 32'd256);
    fetch(32'h000);
    chk("cleared_inst", resp_inst, 32'h0);
    chk("cleared_fault", 32'(resp_fault), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
